// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S codec slave: FSM state encoding, sample widths
// and the serial bit-order helper (I2S_CODEC_MSB_FIRST_EN selects MSB-first).
package i2s_pkg;
  localparam int SAMPLE_W = 32;
  localparam int CNT_W    = 5;
  localparam int PAIR_W   = 2 * SAMPLE_W;

  typedef enum logic [2:0] {
    IDLE_R  = 3'd0,
    CHAN_R  = 3'd1,
    START_R = 3'd2,
    IDLE_L  = 3'd3,
    CHAN_L  = 3'd4,
    START_L = 3'd5
  } state_t;

  // Maps the running bit counter onto the sample bit that travels on the wire.
  function automatic logic [CNT_W-1:0] f_bit_idx(input logic [CNT_W-1:0] cnt);
`ifdef I2S_CODEC_MSB_FIRST_EN
    return ~cnt;
`else
    return cnt;
`endif
  endfunction
endpackage

// File: rtl/i2s_sample_fifo.sv
// Stereo-pair FIFO with valid/ready on both sides; a pop frees a slot for a push in the same clk.
module i2s_sample_fifo import i2s_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = PAIR_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push_valid,
  output logic         o_push_ready,
  input  logic [W-1:0] i_push_data,
  output logic         o_pop_valid,
  input  logic         i_pop_ready,
  output logic [W-1:0] o_pop_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty      = (r_wp == r_rp);
  assign w_full       = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop        = i_pop_ready && !w_empty;
  assign o_pop_valid  = !w_empty;
  assign o_push_ready = !w_full || w_pop;
  assign w_push       = i_push_valid && o_push_ready;
  assign o_pop_data   = w_empty ? '0 : r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_push_data;
  end
endmodule

// File: rtl/i2s_codec_slave.sv
// I2S slave frame engine with tx/rx stereo FIFOs. Bit order is LSB-first unless
// I2S_CODEC_MSB_FIRST_EN is defined, in which case bit 31 goes first.
module i2s_codec_slave import i2s_pkg::*; #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                bclk_i,
  input  logic                lrclk_i,
  input  logic                sdin,
  output logic                sdout,
  input  logic [SAMPLE_W-1:0] tx_l,
  input  logic [SAMPLE_W-1:0] tx_r,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [SAMPLE_W-1:0] rx_l,
  output logic [SAMPLE_W-1:0] rx_r,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                tx_underrun,
  output logic                rx_overrun,
  output logic                frame_err
);
  logic [2:0]          r_sync [SYNC_STAGES];
  logic [2:0]          r_edge_d;
  logic [2:0]          w_sync_out;
  logic                w_bclk_rise, w_bclk_fall, w_lr_rise, w_lr_fall, w_sdin;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sdout, r_bad;
  logic                r_tx_underrun, r_rx_overrun, r_frame_err;
  logic [SAMPLE_W-1:0] r_tx_l, r_tx_r, r_cap_l, r_cap_r, w_tx_cur;
  logic [PAIR_W-1:0]   w_tx_head;
  logic                w_tx_head_vld, w_rx_push_rdy;
  logic                w_is_left, w_in_frame, w_is_start, w_err_edge;
  logic                w_enter_start_l, w_rx_push;

  // Bits: [0] bclk, [1] lrclk, [2] sdin; sdin rides the same pipeline so it stays aligned.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_edge_d <= '0;
    end else begin
      r_sync[0] <= {sdin, lrclk_i, bclk_i};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_edge_d <= w_sync_out;
    end
  end

  assign w_sync_out  = r_sync[SYNC_STAGES-1];
  assign w_bclk_rise =  w_sync_out[0] && !r_edge_d[0];
  assign w_bclk_fall = !w_sync_out[0] &&  r_edge_d[0];
  assign w_lr_rise   =  w_sync_out[1] && !r_edge_d[1];
  assign w_lr_fall   = !w_sync_out[1] &&  r_edge_d[1];
  assign w_sdin      = r_edge_d[2];

  assign w_is_left  = (r_state == START_L) || (r_state == CHAN_L);
  assign w_is_start = (r_state == START_L) || (r_state == START_R);
  assign w_in_frame = w_is_left || (r_state == START_R) || (r_state == CHAN_R);
  assign w_err_edge = w_is_left ? w_lr_rise : w_lr_fall;
  assign w_tx_cur   = w_is_left ? r_tx_l : r_tx_r;

  // A new frame starts on any lrclk fall seen in IDLE_R or while the right channel is busy.
  assign w_enter_start_l = enable && w_lr_fall &&
                           ((r_state == IDLE_R) || (w_in_frame && !w_is_left));
  assign w_rx_push = enable && (r_state == CHAN_R) && !w_lr_fall && w_bclk_fall &&
                     (r_cnt == CNT_W'(SAMPLE_W-1)) && !r_bad;

  i2s_sample_fifo #(.DEPTH(DEPTH), .W(PAIR_W)) u_tx_fifo (
    .clk(clk), .rstn(rstn),
    .i_push_valid(tx_valid), .o_push_ready(tx_ready), .i_push_data({tx_l, tx_r}),
    .o_pop_valid(w_tx_head_vld), .i_pop_ready(w_enter_start_l), .o_pop_data(w_tx_head)
  );

  i2s_sample_fifo #(.DEPTH(DEPTH), .W(PAIR_W)) u_rx_fifo (
    .clk(clk), .rstn(rstn),
    .i_push_valid(w_rx_push), .o_push_ready(w_rx_push_rdy), .i_push_data({r_cap_l, r_cap_r}),
    .o_pop_valid(rx_valid), .i_pop_ready(rx_ready), .o_pop_data({rx_l, rx_r})
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE_R;
      r_cnt         <= '0;
      r_sdout       <= 1'b0;
      r_bad         <= 1'b0;
      r_tx_l        <= '0;
      r_tx_r        <= '0;
      r_cap_l       <= '0;
      r_cap_r       <= '0;
      r_tx_underrun <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_tx_underrun <= w_enter_start_l && !w_tx_head_vld;
      r_rx_overrun  <= w_rx_push && !w_rx_push_rdy;
      r_frame_err   <= 1'b0;
      if (w_enter_start_l) begin
        // An empty FIFO reads as zero, so an underrun frame sends silence.
        r_tx_l  <= w_tx_head[PAIR_W-1:SAMPLE_W];
        r_tx_r  <= w_tx_head[SAMPLE_W-1:0];
        r_cap_l <= '0;
        r_bad   <= 1'b0;
      end
      if (!enable) begin
        r_state <= IDLE_R;
        r_cnt   <= '0;
        r_sdout <= 1'b0;
        r_bad   <= 1'b0;
      end else begin
        case (r_state)
          IDLE_R: if (w_lr_fall) begin
            r_state <= START_L;
            r_cnt   <= '0;
          end
          IDLE_L: if (w_lr_rise) begin
            r_state <= START_R;
            r_cnt   <= '0;
            r_cap_r <= '0;
          end
          START_L, CHAN_L, START_R, CHAN_R: begin
            if (w_err_edge) begin
              r_frame_err <= 1'b1;
              r_sdout     <= 1'b0;
              r_cnt       <= '0;
              if (w_is_left) begin
                r_state <= START_R;
                r_bad   <= 1'b1;
                r_cap_r <= '0;
              end else begin
                r_state <= START_L;
              end
            end else if (w_bclk_fall) begin
              if (w_is_start) begin
                r_state <= w_is_left ? CHAN_L : CHAN_R;
                r_cnt   <= '0;
                r_sdout <= w_tx_cur[f_bit_idx(CNT_W'(0))];
              end else if (r_cnt == CNT_W'(SAMPLE_W-1)) begin
                r_state <= w_is_left ? IDLE_L : IDLE_R;
                r_sdout <= 1'b0;
              end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_sdout <= w_tx_cur[f_bit_idx(r_cnt + CNT_W'(1))];
              end
            end else if (w_bclk_rise && !w_is_start) begin
              if (w_is_left) r_cap_l[f_bit_idx(r_cnt)] <= w_sdin;
              else           r_cap_r[f_bit_idx(r_cnt)] <= w_sdin;
            end
          end
          default: begin
            r_state <= IDLE_R;
            r_sdout <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sdout       = r_sdout;
  assign tx_underrun = r_tx_underrun;
  assign rx_overrun  = r_rx_overrun;
  assign frame_err   = r_frame_err;
endmodule
